// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared constants and types for the PS/2 scancode receiver.
//   PS2_EXT        : extended-key prefix byte
//   PS2_BRK        : break (key release) prefix byte
//   PS2_PAUSE      : Pause-key sequence introducer
//   PS2_PAUSE_SKIP : bytes that follow PS2_PAUSE and carry no key event
//   frame_state_e  : states of the 11-bit frame receiver
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam int         PS2_PAUSE_SKIP = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if -- decoded key-event bus.
//   key_strobe   : one-cycle pulse, a key event is valid
//   key_code     : scancode byte of the event (held)
//   key_pressed  : 1 = make, 0 = break (held)
//   key_extended : E0 prefix preceded the code (held)
//   rx_error     : one-cycle pulse on any frame error
// master = receiver driving events, slave = consumer.
interface ps2_scancode_rx_if;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic       rx_error;

  modport master (
    output key_strobe, key_code, key_pressed, key_extended, rx_error
  );

  modport slave (
    input key_strobe, key_code, key_pressed, key_extended, rx_error
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx -- PS/2 device-to-host frame receiver.
// Synchronizes and deglitches ps2_clk, samples ps2_data on each filtered
// falling edge and assembles start/8 data/parity/stop frames.
//   clk_sys, reset : system clock, synchronous active-high reset
//   ps2_clk        : raw PS/2 clock (async)
//   ps2_data       : raw PS/2 data (async)
//   rx_byte        : last good data byte (valid with byte_valid)
//   byte_valid     : one-cycle pulse, rx_byte holds a good frame
//   frame_err      : one-cycle pulse on start/parity/stop/timeout error
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW   = $clog2(FILTER_LEN + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  logic [1:0]   clk_sync, dat_sync;
  logic         clk_filt;
  logic [FW-1:0] filt_cnt;
  logic         fall_q;   // filtered falling edge, one cycle
  logic         bit_q;    // data bit captured at that edge

  frame_state_e state;
  logic [7:0]   shreg;
  logic [2:0]   bit_cnt;
  logic         par_ok;
  logic [TW-1:0] to_cnt;

  // Synchronizers and clock filter. The filtered clock only moves after
  // FILTER_LEN consecutive synchronized samples disagree with it; data is
  // captured at the moment of the falling flip, well inside the low phase.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall_q   <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        clk_filt <= clk_sync[1];
        if (clk_filt) begin
          fall_q <= 1'b1;
          bit_q  <= dat_sync[1];
        end
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM with inter-edge timeout.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall_q) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;

      if (state != IDLE && !fall_q && to_cnt == TW'(TIMEOUT - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall_q) begin
        case (state)
          IDLE: begin
            if (!bit_q) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {bit_q, shreg[7:1]};   // LSB arrives first
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{bit_q, shreg};        // odd parity over 9 bits
            state  <= STOP;
          end
          STOP: begin
            if (bit_q && par_ok) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx -- PS/2 keyboard scancode receiver (set 2).
// Frames are received by ps2_frame_rx; this level folds E0/F0 prefixes
// into flags, swallows the Pause sequence and registers key events.
//   clk_sys, reset : system clock, synchronous active-high reset
//   ps2_clk        : raw PS/2 clock (async, never driven)
//   ps2_data       : raw PS/2 data (async, never driven)
//   key            : decoded event bus (master side)
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_scancode_rx_if.master key
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  logic       ext, brk;
  logic [2:0] skip_cnt;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_frame (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // byte_valid and frame_err are mutually exclusive, so the strobe and
  // rx_error can never coincide.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext              <= 1'b0;
      brk              <= 1'b0;
      skip_cnt         <= '0;
      key.key_strobe   <= 1'b0;
      key.rx_error     <= 1'b0;
      key.key_code     <= '0;
      key.key_pressed  <= 1'b0;
      key.key_extended <= 1'b0;
    end else begin
      key.key_strobe <= 1'b0;
      key.rx_error   <= frame_err;
      if (frame_err) begin
        // A broken frame drops any half-built prefix state.
        ext      <= 1'b0;
        brk      <= 1'b0;
        skip_cnt <= '0;
      end else if (byte_valid) begin
        if (skip_cnt != '0) begin
          skip_cnt <= skip_cnt - 1'b1;
          ext      <= 1'b0;
          brk      <= 1'b0;
        end else if (rx_byte == PS2_PAUSE) begin
          skip_cnt <= 3'(PS2_PAUSE_SKIP);
          ext      <= 1'b0;
          brk      <= 1'b0;
        end else if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          key.key_strobe   <= 1'b1;
          key.key_code     <= rx_byte;
          key.key_pressed  <= ~brk;
          key.key_extended <= ext;
          ext              <= 1'b0;
          brk              <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int FLEN = 4;
  localparam int TOUT = 400;
  localparam int HALF = 20;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ps2_clk_drv = 1'b1;
  logic glitch = 1'b0;
  logic glitch_en = 1'b0;
  logic ps2_data = 1'b1;
  logic ps2_clk;
  assign ps2_clk = ps2_clk_drv ^ glitch;

  ps2_scancode_rx_if key_if ();

  ps2_scancode_rx #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (key_if.master)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int err_seen = 0;
  logic [9:0] obs_q[$];   // {extended, pressed, code}
  logic [9:0] exp_q[$];
  int exp_err = 0;

  // reference decoder state
  bit m_ext, m_brk;
  int m_skip;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    int g = 0;
    forever begin
      @(negedge clk_sys);
      g++;
      glitch = glitch_en && (g % 100 == 0);
    end
  end

  // event monitor
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (key_if.key_strobe || key_if.rx_error)
        check("strobe_err_exclusive", {31'd0, key_if.key_strobe & key_if.rx_error}, 32'd0);
      if (key_if.key_strobe) begin
        obs_q.push_back({key_if.key_extended, key_if.key_pressed, key_if.key_code});
        check("latency_window",
              {31'd0, (cyc - last_fall >= FLEN + 2) && (cyc - last_fall <= FLEN + 6)}, 32'd1);
      end
      if (key_if.rx_error) err_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference rules: prefixes accumulate into flags; any ordinary byte is a
  // key event; the Pause introducer hides the following 7 bytes.
  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0)     m_brk = 1;
    else begin
      exp_q.push_back({m_ext, ~m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_err();
    m_ext = 0; m_brk = 0; m_skip = 0;
    exp_err++;
  endtask

  // Drive the first nbits of an 11-bit frame, clock idling high between bits.
  task automatic drive_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_sys);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_drv = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_drv = 1'b1;
    end
    repeat (HALF) @(negedge clk_sys);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_frame(b, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic send_bad(input logic [7:0] b);
    drive_frame(b, 1'b1, 11);
    model_err();
  endtask

  task automatic finish_scenario(input string tag);
    int n;
    repeat (60) @(negedge clk_sys);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_code"},     {24'd0, obs_q[i][7:0]}, {24'd0, exp_q[i][7:0]});
      check({tag, "_pressed"},  {31'd0, obs_q[i][8]},   {31'd0, exp_q[i][8]});
      check({tag, "_extended"}, {31'd0, obs_q[i][9]},   {31'd0, exp_q[i][9]});
    end
    check({tag, "_rx_error"}, err_seen, exp_err);
    obs_q.delete(); exp_q.delete();
    err_seen = 0; exp_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"},   {31'd0, key_if.key_strobe},   32'd0);
    check({tag, "_rx_error"}, {31'd0, key_if.rx_error},     32'd0);
    check({tag, "_code"},     {24'd0, key_if.key_code},     32'd0);
    check({tag, "_pressed"},  {31'd0, key_if.key_pressed},  32'd0);
    check({tag, "_extended"}, {31'd0, key_if.key_extended}, 32'd0);
  endtask

  initial begin
    logic [7:0] code;
    int r;
    m_ext = 0; m_brk = 0; m_skip = 0;

    repeat (10) @(negedge clk_sys);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);

    // plain make code
    send_byte(8'h1C);
    finish_scenario("make_1c");

    // break, then extended break
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h6B);
    finish_scenario("prefix");

    // parity error then recovery
    send_bad(8'h29);
    send_byte(8'h29);
    finish_scenario("parity");

    // dangling E0 followed by an aborted partial frame
    send_byte(8'hE0);
    drive_frame(8'h75, 1'b0, 6);
    repeat (TOUT + 10) @(negedge clk_sys);
    check("timeout_err", err_seen, 1);
    check("timeout_idle", {30'd0, dut.u_frame.state}, {30'd0, IDLE});
    model_err();
    send_byte(8'h75);
    finish_scenario("timeout");

    // Pause sequence
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h5A);
    finish_scenario("pause");

    // clock glitches inside a frame
    glitch_en = 1'b1;
    send_byte(8'h12);
    glitch_en = 1'b0;
    finish_scenario("glitch");

    // reset in the middle of a frame
    drive_frame(8'h33, 1'b0, 5);
    reset = 1'b1;
    ps2_clk_drv = 1'b1; ps2_data = 1'b1;
    repeat (20) @(negedge clk_sys);
    check_reset_outputs("midreset");
    reset = 1'b0;
    m_ext = 0; m_brk = 0; m_skip = 0;
    repeat (TOUT + 50) @(negedge clk_sys);
    finish_scenario("midreset");

    // randomized prefix/code mixes with occasional corrupted frames
    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 7);
      do code = 8'($urandom_range(1, 255));
      while (code == 8'hE0 || code == 8'hF0 || code == 8'hE1);
      if (r[0] && r[1] && $urandom_range(0, 1) == 1) begin
        send_byte(8'hF0); send_byte(8'hE0);
      end else begin
        if (r[0]) send_byte(8'hE0);
        if (r[1]) send_byte(8'hF0);
      end
      if (r[2] && $urandom_range(0, 1) == 1) send_bad(8'($urandom));
      send_byte(code);
    end
    finish_scenario("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal samples that validates a change on ps2_clk.
REQ-002 Parameter TIMEOUT, default 50000: idle clk_sys cycles after which a partial frame is aborted.
REQ-003 clk_sys  input  1  system clock; all logic in this single domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-007 key_strobe  output  1  one-cycle pulse when a complete key event is valid.
REQ-008 key_code  output  8  scancode byte of the event, held until the next strobe.
REQ-009 key_pressed  output  1  1 = make, 0 = break (F0 prefix seen), held until the next strobe.
REQ-010 key_extended  output  1  1 = E0 prefix preceded the code, held until the next strobe.
REQ-011 rx_error  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The filtered clock SHALL change state only after FILTER_LEN consecutive identical synchronized samples.
REQ-014 A falling edge of the filtered clock SHALL sample the synchronized ps2_data as one frame bit.
REQ-015 The frame FSM SHALL use states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: a sampled 0 (start bit) SHALL move to DATA; a sampled 1 SHALL pulse rx_error and stay in IDLE.
REQ-017 DATA: SHALL shift 8 bits LSB first, then go to PARITY.
REQ-018 PARITY: SHALL check that the 8 data bits plus the parity bit contain an odd number of ones, then go to STOP.
REQ-019 STOP: a sampled 1 with good parity SHALL deliver the byte to the decoder; a bad stop bit or bad parity SHALL pulse rx_error and discard the byte; either way the FSM SHALL return to IDLE.
REQ-020 In any state other than IDLE, TIMEOUT cycles without a filtered falling edge SHALL return the FSM to IDLE, pulse rx_error and clear the decoder flags.
REQ-021 Decoder: byte E0 SHALL set the ext flag; byte F0 SHALL set the brk flag; neither SHALL strobe.
REQ-022 Decoder: byte E1 SHALL load a skip counter of 7; the next 7 bytes SHALL be discarded without strobing, and the flags SHALL be cleared.
REQ-023 Decoder: any other byte SHALL drive key_code=byte, key_pressed=~brk and key_extended=ext, and pulse key_strobe in the cycle after the STOP sample.
REQ-024 ext and brk SHALL clear in the cycle the strobe is issued.
REQ-025 Prefix order E0,F0 and order F0,E0 SHALL both yield key_extended=1 and key_pressed=0.
REQ-026 A frame error SHALL clear ext and brk, so a dangling prefix never attaches to a later code.
REQ-027 Latency from the STOP-bit sample to key_strobe SHALL be exactly 1 clk_sys cycle.
REQ-028 Strobes SHALL be at least one full PS/2 frame apart, and key_strobe and rx_error SHALL never be high in the same cycle.
REQ-029 Host-to-device transmission is out of scope: ps2_clk and ps2_data are never driven.

Reset
REQ-030 While reset is high: FSM=IDLE, shift register=0, skip counter=0, ext=0, brk=0, timeout counter=0.
REQ-031 While reset is high: key_strobe=0, rx_error=0, key_code=8'h00, key_pressed=0, key_extended=0.
REQ-032 While reset is high the filtered clock and all synchronizer flops SHALL be set to 1 (idle bus).
REQ-033 Reset asserted mid-frame SHALL abandon the frame silently, with no strobe and no rx_error.

Structure
REQ-034 Package ps2_pkg SHALL hold the constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_PAUSE_SKIP=7, and the frame-state enum.
REQ-035 Sub-module ps2_frame_rx SHALL contain the synchronizers, filter, frame FSM and timeout, and SHALL output byte, byte_valid and frame_err.
REQ-036 The top level SHALL contain only the prefix decoder and the output registers.

Verification
REQ-037 Frame 1C with correct parity -> one key_strobe, key_code=1C, key_pressed=1, key_extended=0.
REQ-038 Frames F0,1C -> one strobe, key_code=1C, key_pressed=0; E0,F0,6B -> one strobe, code=6B, pressed=0, extended=1.
REQ-039 Frame 29 with parity bit inverted -> rx_error pulse, no strobe; then frame 29 -> strobe with code=29.
REQ-040 E0 then 6 bits of a frame then silence for TIMEOUT+10 cycles -> rx_error, FSM=IDLE; then frame 75 -> strobe with extended=0.
REQ-041 Sequence E1,14,77,E1,F0,14,F0,77 then frame 5A -> exactly one strobe, code=5A.
REQ-042 1-cycle glitches on ps2_clk every 100 cycles during frame 12 -> single strobe, code=12, no rx_error; reset mid-frame -> no strobe, no rx_error.
